deserialize_stream: RTL and testbench
=====================================

// Module: deserialize_stream
// PURPOSE
//  Collects BIT_WIDTH-bit words arriving serially into a LENGTH-word vector.
//  Full vectors are handed to a systolic-array edge (row or column feeder)
//  through a registered, double-buffered valid/ready output.
//  Successor to the plain shift deserializer. Adds:
//   - input and output handshakes, with back-pressure
//   - a selectable slot order
//   - flush of partial vectors (zero-padded) with a word count
// PARAMETERS
//  LENGTH     8   words per output vector (>=2)
//  BIT_WIDTH  64  bits per word
//  ORDER      0   0: newest word in slot 0, older words shift up; 1: first word in slot 0 (indexed fill)
//  CNT_W      $clog2(LENGTH+1)  width of word counters (derived; do not override)
// PORTS
//  clk        in   1                 clock, all state on posedge
//  rst        in   1                 synchronous, active-high reset
//  in_valid   in   1                 in_data carries a word
//  in_ready   out  1                 block can accept a word this cycle
//  in_data    in   BIT_WIDTH         input word
//  in_flush   in   1                 close the current partial vector
//  out_valid  out  1                 out_vec/out_count hold a vector
//  out_ready  in   1                 consumer takes the vector this cycle
//  out_vec    out  LENGTH*BIT_WIDTH  vector; slot i = out_vec[(i+1)*BIT_WIDTH-1 -: BIT_WIDTH]
//  out_count  out  CNT_W             valid words in out_vec (1..LENGTH)
// BEHAVIOUR
//  - Reset: fill buffer=0, cnt=0, full_q=0, hold=0, out_valid=0, out_vec=0, out_count=0. Takes effect even mid-vector; partial data is discarded.
//  - Input handshake:
//    - in_ready = !full_q (registered state only; no combinational path from out_ready).
//    - A word is accepted when in_valid && in_ready.
//  - Output handshake: hold_free = !out_valid || out_ready.
//  - Fill:
//    - ORDER=0: an accepted word enters slot 0 and slots 0..LENGTH-2 move to 1..LENGTH-1.
//    - ORDER=1: an accepted word is written to slot cnt.
//    - On an accepted word, cnt increments.
//  - Close event: an accepted word makes cnt==LENGTH, or in_flush is asserted with (cnt + accepted word) > 0.
//    - A word accepted in the same cycle as in_flush is included before closing.
//    - in_flush with no pending words and no accepted word is a no-op.
//  - On close with hold_free:
//    - hold <= filled vector; out_count <= word count; out_valid <= 1 at the next edge.
//    - Fill buffer and cnt clear to 0.
//    - Latency: last word accepted at edge N, out_valid visible after edge N.
//    - Full rate: one LENGTH-word vector every LENGTH cycles, no bubble.
//  - On close without hold_free:
//    - full_q <= 1; the vector and its count stay in the fill buffer; in_ready drops.
//    - At the first cycle with full_q && hold_free: transfer to hold, clear fill/cnt/full_q. in_ready returns the cycle after.
//  - Partial vectors:
//    - Unused slots are 0, because the buffer is cleared at each transfer.
//    - ORDER=0: k words occupy slots 0..k-1, newest in slot 0.
//    - ORDER=1: k words occupy slots 0..k-1, oldest in slot 0.
//  - in_flush while full_q is ignored (the vector is already closed).
//  - out_valid && out_ready with no new transfer: out_valid <= 0; out_vec and out_count keep their last value.
//  - out_vec and out_count are stable while out_valid && !out_ready.
//  - States (implicit, from cnt and full_q): EMPTY (cnt=0), FILLING (0<cnt<LENGTH), FULL (full_q=1).
//    - Transitions follow the close rules above.
//    - The hold stage is independent: EMPTY or VALID, tracked by out_valid.
// STRUCTURE
//  - Package deserialize_pkg: localparams ORDER_NEWEST_LOW=0 and ORDER_FIRST_LOW=1; function clog2 for CNT_W.
//  - One sub-module, deserialize_fill: fill buffer, cnt, ORDER write logic, clear.
//  - The top level holds full_q, the hold register, and the handshake glue.
// TESTING
//  1 LENGTH=4, BIT_WIDTH=8, ORDER=0, out_ready=1, in_data 0x01..0x04 back-to-back
//    -> one cycle after the 4th accept: out_valid=1, out_vec=0x01020304, out_count=4.
//  2 Same config, ORDER=1, same words -> out_vec=0x04030201.
//  3 ORDER=0, words 0xA1,0xA2 then in_flush alone -> out_vec=0x0000A1A2, out_count=2.
//    - in_flush with cnt=0 -> no out_valid pulse.
//  4 out_ready=0, stream 8 words
//    -> 1st vector held in hold; 2nd completes with full_q=1 and in_ready=0.
//    -> raise out_ready for 1 cycle: 2nd vector moves to hold; in_ready=1 the next cycle; no data lost or reordered.
//  5 Continuous in_valid and out_ready=1 for 40 words -> 10 vectors, in_ready never 0, out_valid pulses exactly every 4 cycles.
//  6 rst asserted after 2 of 4 words, and again while out_valid=1 && out_ready=0
//    -> next cycle: out_valid=0, in_ready=1, out_vec=0, and the next vector contains only post-reset words.

Source files
------------

// File: rtl/deserialize_pkg.sv
// Shared constants and helpers for the stream deserializer.
// Slot-order encodings and a constant-evaluable clog2.
package deserialize_pkg;

  localparam int ORDER_NEWEST_LOW = 0;
  localparam int ORDER_FIRST_LOW  = 1;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/deserialize_fill.sv
// Fill buffer and word counter for the stream deserializer.
// Exposes the buffer as it would look with this cycle's word included.
module deserialize_fill
  import deserialize_pkg::*;
#(
  parameter int LENGTH    = 8,
  parameter int BIT_WIDTH = 64,
  parameter int ORDER     = ORDER_NEWEST_LOW,
  parameter int CNT_W     = clog2(LENGTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_accept,
  input  logic [BIT_WIDTH-1:0]        i_data,
  input  logic                        i_clear,
  output logic [LENGTH*BIT_WIDTH-1:0] o_vec_next,
  output logic [CNT_W-1:0]            o_cnt_next
);

  logic [LENGTH*BIT_WIDTH-1:0] r_buf;
  logic [CNT_W-1:0]            r_cnt;
  logic [LENGTH*BIT_WIDTH-1:0] w_vec;
  logic [CNT_W-1:0]            w_cnt;

  always_comb begin
    w_vec = r_buf;
    w_cnt = r_cnt;
    if (i_accept) begin
      w_cnt = r_cnt + CNT_W'(1);
      if (ORDER == ORDER_NEWEST_LOW) begin
        w_vec = {r_buf[(LENGTH-1)*BIT_WIDTH-1:0], i_data};
      end else begin
        for (int i = 0; i < LENGTH; i++) begin
          if (r_cnt == CNT_W'(i))
            w_vec[i*BIT_WIDTH +: BIT_WIDTH] = i_data;
        end
      end
    end
  end

  // Clearing on transfer is what zero-pads later partial vectors.
  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_buf <= '0;
      r_cnt <= '0;
    end else if (i_accept) begin
      r_buf <= w_vec;
      r_cnt <= w_cnt;
    end
  end

  assign o_vec_next = w_vec;
  assign o_cnt_next = w_cnt;

endmodule

// File: rtl/deserialize_stream.sv
// Serial-to-vector deserializer with valid/ready on both sides.
// A closed vector waits in the fill buffer while the hold stage is busy.
module deserialize_stream
  import deserialize_pkg::*;
#(
  parameter int LENGTH    = 8,
  parameter int BIT_WIDTH = 64,
  parameter int ORDER     = ORDER_NEWEST_LOW,
  parameter int CNT_W     = clog2(LENGTH + 1)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [BIT_WIDTH-1:0]        in_data,
  input  logic                        in_flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LENGTH*BIT_WIDTH-1:0] out_vec,
  output logic [CNT_W-1:0]            out_count
);

  logic                        r_full;
  logic                        r_out_valid;
  logic [LENGTH*BIT_WIDTH-1:0] r_hold_vec;
  logic [CNT_W-1:0]            r_hold_cnt;

  logic                        w_accept;
  logic                        w_hold_free;
  logic                        w_close;
  logic                        w_xfer;
  logic [LENGTH*BIT_WIDTH-1:0] w_vec_next;
  logic [CNT_W-1:0]            w_cnt_next;

  assign w_accept    = in_valid && !r_full;
  assign w_hold_free = !r_out_valid || out_ready;
  assign w_close     = !r_full &&
                       ((w_accept && w_cnt_next == CNT_W'(LENGTH)) ||
                        (in_flush && w_cnt_next != '0));
  assign w_xfer      = (w_close || r_full) && w_hold_free;

  deserialize_fill #(
    .LENGTH    (LENGTH),
    .BIT_WIDTH (BIT_WIDTH),
    .ORDER     (ORDER),
    .CNT_W     (CNT_W)
  ) u_fill (
    .clk        (clk),
    .rst        (rst),
    .i_accept   (w_accept),
    .i_data     (in_data),
    .i_clear    (w_xfer),
    .o_vec_next (w_vec_next),
    .o_cnt_next (w_cnt_next)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full      <= 1'b0;
      r_out_valid <= 1'b0;
      r_hold_vec  <= '0;
      r_hold_cnt  <= '0;
    end else begin
      if (w_xfer) begin
        r_full      <= 1'b0;
        r_out_valid <= 1'b1;
        r_hold_vec  <= w_vec_next;
        r_hold_cnt  <= w_cnt_next;
      end else begin
        if (w_close) r_full <= 1'b1;
        if (out_ready) r_out_valid <= 1'b0;
      end
    end
  end

  assign in_ready  = !r_full;
  assign out_valid = r_out_valid;
  assign out_vec   = r_hold_vec;
  assign out_count = r_hold_cnt;

endmodule

// File: tb/tb_deserialize_stream.sv
// Bench for deserialize_stream: both slot orders run side by side
// against a word-queue model plus literal expectations.
module tb_deserialize_stream;

  localparam int L  = 4;
  localparam int BW = 8;
  localparam int CW = 3;

  logic          clk = 0;
  logic          rst = 1;
  logic          in_valid = 0;
  logic          in_flush = 0;
  logic          out_ready = 1;
  logic [BW-1:0] in_data = '0;

  logic          ir0, ov0, ir1, ov1;
  logic [L*BW-1:0] vec0, vec1;
  logic [CW-1:0] cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  deserialize_stream #(.LENGTH(L), .BIT_WIDTH(BW), .ORDER(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir0),
    .in_data(in_data), .in_flush(in_flush), .out_valid(ov0),
    .out_ready(out_ready), .out_vec(vec0), .out_count(cnt0)
  );

  deserialize_stream #(.LENGTH(L), .BIT_WIDTH(BW), .ORDER(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ir1),
    .in_data(in_data), .in_flush(in_flush), .out_valid(ov1),
    .out_ready(out_ready), .out_vec(vec1), .out_count(cnt1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Model: pending words, closed flag, and the words of the held vector.
  logic [7:0] m_words[$];
  logic [7:0] m_hold[$];
  bit         m_full = 0;
  bit         m_ov   = 0;
  bit         m_init = 0;

  function automatic logic [L*BW-1:0] mvec(input int ord);
    logic [L*BW-1:0] v;
    int k;
    v = '0;
    k = m_hold.size();
    for (int i = 0; i < k; i++)
      v[i*BW +: BW] = (ord == 0) ? m_hold[k-1-i] : m_hold[i];
    return v;
  endfunction

  always @(posedge clk) begin
    bit hf, acc, cl;
    m_init = 1;
    if (rst) begin
      m_words.delete();
      m_hold.delete();
      m_full = 0;
      m_ov   = 0;
    end else begin
      hf  = !m_ov || out_ready;
      acc = in_valid && !m_full;
      if (acc) m_words.push_back(in_data);
      cl = !m_full && ((acc && m_words.size() == L) ||
                       (in_flush && m_words.size() > 0));
      if ((cl || m_full) && hf) begin
        m_hold = m_words;
        m_words.delete();
        m_full = 0;
        m_ov   = 1;
      end else begin
        if (cl) m_full = 1;
        if (out_ready) m_ov = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("in_ready0", 64'(ir0), 64'(!m_full));
      chk("in_ready1", 64'(ir1), 64'(!m_full));
      chk("out_valid0", 64'(ov0), 64'(m_ov));
      chk("out_valid1", 64'(ov1), 64'(m_ov));
      chk("out_count0", 64'(cnt0), 64'(m_hold.size()));
      chk("out_count1", 64'(cnt1), 64'(m_hold.size()));
      chk("out_vec0", 64'(vec0), 64'(mvec(0)));
      chk("out_vec1", 64'(vec1), 64'(mvec(1)));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d);
    in_valid = 1;
    in_data  = d;
    tick();
    in_valid = 0;
  endtask

  int bad_ir, bad_ov, nvec;

  initial begin
    rst = 1;
    tick();
    tick();
    chk("reset_ov", 64'(ov0), 64'(0));
    chk("reset_vec", 64'(vec0), 64'(0));
    chk("reset_ir", 64'(ir0), 64'(1));
    rst = 0;
    out_ready = 1;

    // Full vector, both orders
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1;
      in_data  = 8'(i);
      tick();
    end
    in_valid = 0;
    chk("t1_ov", 64'(ov0), 64'(1));
    chk("t1_vec_o0", 64'(vec0), 64'h01020304);
    chk("t2_vec_o1", 64'(vec1), 64'h04030201);
    chk("t1_cnt", 64'(cnt0), 64'(4));
    tick();
    chk("t1_ov_drop", 64'(ov0), 64'(0));

    // Flush of a partial vector
    send(8'hA1);
    send(8'hA2);
    in_flush = 1;
    tick();
    in_flush = 0;
    chk("t3_ov", 64'(ov0), 64'(1));
    chk("t3_vec_o0", 64'(vec0), 64'h0000A1A2);
    chk("t3_vec_o1", 64'(vec1), 64'h0000A2A1);
    chk("t3_cnt", 64'(cnt1), 64'(2));
    tick();
    in_flush = 1;
    tick();
    in_flush = 0;
    chk("t3_empty_flush", 64'(ov0), 64'(0));

    // Back-pressure: second vector parks in the fill buffer
    out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      in_valid = 1;
      in_data  = 8'(8'h11 + i);
      tick();
    end
    in_valid = 0;
    chk("t4_ir_low", 64'(ir0), 64'(0));
    chk("t4_hold1", 64'(vec0), 64'h11121314);
    tick();
    tick();
    chk("t4_stable", 64'(vec1), 64'h14131211);
    out_ready = 1;
    tick();
    chk("t4_ir_back", 64'(ir0), 64'(1));
    chk("t4_hold2_o0", 64'(vec0), 64'h15161718);
    chk("t4_hold2_o1", 64'(vec1), 64'h18171615);
    chk("t4_ov", 64'(ov1), 64'(1));
    tick();

    // Full-rate streaming
    bad_ir = 0;
    bad_ov = 0;
    nvec   = 0;
    for (int i = 0; i < 40; i++) begin
      in_valid = 1;
      in_data  = 8'(i);
      tick();
      if (ir0 !== 1'b1) bad_ir++;
      if (ov0 !== ((i % 4) == 3)) bad_ov++;
      if (ov0 === 1'b1) nvec++;
    end
    in_valid = 0;
    chk("t5_ir_drops", 64'(bad_ir), 64'(0));
    chk("t5_ov_pattern", 64'(bad_ov), 64'(0));
    chk("t5_vectors", 64'(nvec), 64'(10));
    chk("t5_last_vec", 64'(vec0), 64'h24252627);
    tick();

    // Reset mid-vector
    send(8'h21);
    send(8'h22);
    rst = 1;
    tick();
    rst = 0;
    chk("t6_ov", 64'(ov0), 64'(0));
    chk("t6_ir", 64'(ir0), 64'(1));
    chk("t6_vec", 64'(vec0), 64'(0));
    for (int i = 0; i < 4; i++) send(8'(8'h31 + i));
    chk("t6_post", 64'(vec0), 64'h31323334);
    tick();

    // Reset while a vector is held
    out_ready = 0;
    for (int i = 0; i < 4; i++) send(8'(8'h51 + i));
    send(8'h61);
    chk("t6_held", 64'(ov0), 64'(1));
    rst = 1;
    tick();
    rst = 0;
    out_ready = 1;
    chk("t6b_ov", 64'(ov1), 64'(0));
    chk("t6b_ir", 64'(ir1), 64'(1));
    chk("t6b_vec", 64'(vec1), 64'(0));
    for (int i = 0; i < 4; i++) send(8'(8'h41 + i));
    chk("t6b_post_o0", 64'(vec0), 64'h41424344);
    chk("t6b_post_o1", 64'(vec1), 64'h44434241);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
